// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the ALU issue stage:
//   - ALU control codes (3-bit, bit 2 is always 0)
//   - RV32 major opcode and funct3 constants used by the decoder
//   - operand-select enum shared by the decoder and the operand muxes
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 values for the supported arithmetic/logic operations
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // Source of an ALU operand
    typedef enum logic [1:0] {
        SEL_REG  = 2'd0,
        SEL_IMM  = 2'd1,
        SEL_PC   = 2'd2,
        SEL_ZERO = 2'd3
    } opsel_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dec
// Purely combinational decode of opcode/funct3/funct7[5] into the ALU control
// code, the A/B operand sources, a write-enable class and an illegal flag.
// The write enable here does not account for rd==x0; the caller masks that.
//
// Ports:
//   i_opcode    in  7  instr[6:0]
//   i_funct3    in  3  instr[14:12]
//   i_funct7b5  in  1  instr[30]
//   o_ctrl      out 3  ALU control code
//   o_a_sel     out    operand A source (opsel_e)
//   o_b_sel     out    operand B source (opsel_e)
//   o_wen       out 1  instruction class writes rd
//   o_illegal   out 1  unsupported encoding
// -----------------------------------------------------------------------------
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [2:0] o_ctrl,
    output opsel_e     o_a_sel,
    output opsel_e     o_b_sel,
    output logic       o_wen,
    output logic       o_illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_ctrl    = ALU_ADD;
        o_a_sel   = SEL_ZERO;
        o_b_sel   = SEL_ZERO;
        o_wen     = 1'b0;
        o_illegal = 1'b0;

        case (i_opcode)
            OPC_OP: begin
                o_a_sel = SEL_REG;
                o_b_sel = SEL_REG;
                o_wen   = 1'b1;
                case (i_funct3)
                    F3_ADD:  o_ctrl = i_funct7b5 ? ALU_SUB : ALU_ADD;
                    F3_AND:  o_ctrl = ALU_AND;
                    F3_OR:   o_ctrl = ALU_OR;
                    default: begin
                        o_a_sel   = SEL_ZERO;
                        o_b_sel   = SEL_ZERO;
                        o_wen     = 1'b0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP_IMM: begin
                // funct7b5 is an immediate bit here, so ADDI never becomes SUB
                o_a_sel = SEL_REG;
                o_b_sel = SEL_IMM;
                o_wen   = 1'b1;
                case (i_funct3)
                    F3_ADD:  o_ctrl = ALU_ADD;
                    F3_AND:  o_ctrl = ALU_AND;
                    F3_OR:   o_ctrl = ALU_OR;
                    default: begin
                        o_a_sel   = SEL_ZERO;
                        o_b_sel   = SEL_ZERO;
                        o_wen     = 1'b0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                o_a_sel = SEL_REG;
                o_b_sel = SEL_IMM;
                o_wen   = 1'b1;
            end
            OPC_STORE: begin
                o_a_sel = SEL_REG;
                o_b_sel = SEL_IMM;
            end
            OPC_BRANCH: begin
                o_ctrl  = ALU_SUB;
                o_a_sel = SEL_REG;
                o_b_sel = SEL_REG;
            end
            OPC_LUI: begin
                o_a_sel = SEL_ZERO;
                o_b_sel = SEL_IMM;
                o_wen   = 1'b1;
            end
            OPC_AUIPC: begin
                o_a_sel = SEL_PC;
                o_b_sel = SEL_IMM;
                o_wen   = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// One-entry execute-issue pipeline register in front of the 32-bit ALU.
// Decodes opcode/funct fields into the ALU control code, selects operands
// (register file / forwarded value / immediate / PC / zero) and registers
// A, B, control and writeback metadata behind a valid/ready handshake.
//
// Configuration macro: ALU_ISSUE_FWD_EN
//   defined   - MEM/WB forwarding on capture, plus refresh of held register
//               operands while the entry is stalled.
//   undefined - fwd_* inputs are ignored; operands never change while held.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid / in_ready                 decode handshake
//   in_opcode, in_funct3, in_funct7b5   instruction fields
//   in_pc, in_imm                       PC and sign-extended immediate
//   in_rs1, in_rs2, in_rd               register indices
//   in_rs1_data, in_rs2_data            register-file read data
//   flush                               kill held and incoming instruction
//   fwd_{mem,wb}_{valid,rd,data}        forwarding sources (MEM beats WB)
//   out_valid / out_ready               ALU handshake
//   alu_a, alu_b, alu_ctrl              registered ALU inputs
//   out_rd, out_wen, out_illegal        writeback metadata
// -----------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_pc,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [REGW-1:0] in_rd,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            flush,
    input  logic            fwd_mem_valid,
    input  logic            fwd_wb_valid,
    input  logic [REGW-1:0] fwd_mem_rd,
    input  logic [REGW-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    output logic [REGW-1:0] out_rd,
    output logic            out_wen,
    output logic            out_illegal
);

    // Decoder outputs
    logic [2:0] w_ctrl;
    opsel_e     w_a_sel;
    opsel_e     w_b_sel;
    logic       w_wen;
    logic       w_illegal;

    alu_ctrl_dec u_dec (
        .i_opcode   (in_opcode),
        .i_funct3   (in_funct3),
        .i_funct7b5 (in_funct7b5),
        .o_ctrl     (w_ctrl),
        .o_a_sel    (w_a_sel),
        .o_b_sel    (w_b_sel),
        .o_wen      (w_wen),
        .o_illegal  (w_illegal)
    );

    // Pipeline register
    logic            r_valid;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [2:0]      r_ctrl;
    logic [REGW-1:0] r_rd;
    logic            r_wen;
    logic            r_illegal;
    // Held source indices and whether each operand came from a register;
    // only register operands are eligible for refresh while stalled.
    logic [REGW-1:0] r_rs1;
    logic [REGW-1:0] r_rs2;
    logic            r_a_is_reg;
    logic            r_b_is_reg;

    logic            w_accept;
    logic            w_hold;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_hold_a;
    logic [XLEN-1:0] w_hold_b;
    logic [XLEN-1:0] w_a_next;
    logic [XLEN-1:0] w_b_next;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_hold   = r_valid && !out_ready;

`ifdef ALU_ISSUE_FWD_EN
    // Youngest matching producer wins; x0 is hard-wired zero and never forwarded.
    function automatic logic [XLEN-1:0] fwd_pick(input logic [REGW-1:0] rs,
                                                 input logic [XLEN-1:0] base);
        fwd_pick = base;
        if (rs != '0) begin
            if (fwd_mem_valid && (fwd_mem_rd == rs))
                fwd_pick = fwd_mem_data;
            else if (fwd_wb_valid && (fwd_wb_rd == rs))
                fwd_pick = fwd_wb_data;
        end
    endfunction

    assign w_rs1_val = fwd_pick(in_rs1, in_rs1_data);
    assign w_rs2_val = fwd_pick(in_rs2, in_rs2_data);
    assign w_hold_a  = r_a_is_reg ? fwd_pick(r_rs1, r_alu_a) : r_alu_a;
    assign w_hold_b  = r_b_is_reg ? fwd_pick(r_rs2, r_alu_b) : r_alu_b;
`else
    assign w_rs1_val = in_rs1_data;
    assign w_rs2_val = in_rs2_data;
    assign w_hold_a  = r_alu_a;
    assign w_hold_b  = r_alu_b;

    // Forwarding inputs and held indices have no consumer in this build.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_mem_valid, fwd_wb_valid, fwd_mem_rd, fwd_wb_rd,
                            fwd_mem_data, fwd_wb_data, r_rs1, r_rs2,
                            r_a_is_reg, r_b_is_reg};
`endif

    // Operand muxes
    always_comb begin
        w_a_next = '0;
        case (w_a_sel)
            SEL_REG: w_a_next = w_rs1_val;
            SEL_IMM: w_a_next = in_imm;
            SEL_PC:  w_a_next = in_pc;
            default: w_a_next = '0;
        endcase
    end

    always_comb begin
        w_b_next = '0;
        case (w_b_sel)
            SEL_REG: w_b_next = w_rs2_val;
            SEL_IMM: w_b_next = in_imm;
            SEL_PC:  w_b_next = in_pc;
            default: w_b_next = '0;
        endcase
    end

    // Priority: flush > capture > drain/refresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            r_valid    <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_ctrl     <= ALU_ADD;
            r_rd       <= '0;
            r_wen      <= 1'b0;
            r_illegal  <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_a_is_reg <= 1'b0;
            r_b_is_reg <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_alu_a    <= w_a_next;
            r_alu_b    <= w_b_next;
            r_ctrl     <= w_ctrl;
            r_rd       <= in_rd;
            r_wen      <= w_wen && (in_rd != '0);
            r_illegal  <= w_illegal;
            r_rs1      <= in_rs1;
            r_rs2      <= in_rs2;
            r_a_is_reg <= (w_a_sel == SEL_REG);
            r_b_is_reg <= (w_b_sel == SEL_REG);
        end else if (w_hold) begin
            r_alu_a <= w_hold_a;
            r_alu_b <= w_hold_b;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctrl    = r_ctrl;
    assign out_rd      = r_rd;
    assign out_wen     = r_wen;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed self-checking bench for alu_issue_stage. Expected values are
// hand-computed; forwarding-dependent expectations follow ALU_ISSUE_FWD_EN.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        flush;
    logic        fwd_mem_valid, fwd_wb_valid;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_stage #(.XLEN(32), .REGW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_funct7b5   (in_funct7b5),
        .in_pc         (in_pc),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .flush         (flush),
        .fwd_mem_valid (fwd_mem_valid),
        .fwd_wb_valid  (fwd_wb_valid),
        .fwd_mem_rd    (fwd_mem_rd),
        .fwd_wb_rd     (fwd_wb_rd),
        .fwd_mem_data  (fwd_mem_data),
        .fwd_wb_data   (fwd_wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ctrl      (alu_ctrl),
        .out_rd        (out_rd),
        .out_wen       (out_wen),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm);
        in_valid    = 1'b1;
        in_opcode   = op;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_pc       = pc;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rd       = rd;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
    endtask

    task automatic clear_fwd();
        fwd_mem_valid = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
        fwd_wb_valid  = 1'b0; fwd_wb_rd  = '0; fwd_wb_data  = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(7'd0, 3'd0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        in_valid  = 1'b0;
        clear_fwd();

        // Reset state
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_wen", out_wen, 0);
        check("rst_out_illegal", out_illegal, 0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1);

        // R-type SUB: 10 - 3
        drive(7'b0110011, 3'b000, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'h0);
        step();
        in_valid = 1'b0;
        check("sub_valid", out_valid, 1);
        check("sub_a", alu_a, 10);
        check("sub_b", alu_b, 3);
        check("sub_ctrl", alu_ctrl, 3'b001);
        check("sub_wen", out_wen, 1);
        check("sub_rd", out_rd, 3);
        step();
        check("sub_drained", out_valid, 0);

        // ORI with MEM and WB both hitting x5: MEM wins
        fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h100;
        fwd_wb_valid  = 1'b1; fwd_wb_rd  = 5'd5; fwd_wb_data  = 32'h200;
        drive(7'b0010011, 3'b110, 1'b0, 32'h0, 5'd5, 5'd0, 5'd6, 32'h777, 32'h0, 32'h0F0);
        step();
        in_valid = 1'b0;
        clear_fwd();
        check("ori_a", alu_a, FWD ? 32'h100 : 32'h777);
        check("ori_b", alu_b, 32'h0F0);
        check("ori_ctrl", alu_ctrl, 3'b011);

        // ADDI with only WB hitting x4
        fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'h33;
        drive(7'b0010011, 3'b000, 1'b0, 32'h0, 5'd4, 5'd0, 5'd4, 32'h1, 32'h0, 32'h8);
        step();
        in_valid = 1'b0;
        clear_fwd();
        check("addi_wb_a", alu_a, FWD ? 32'h33 : 32'h1);
        check("addi_ctrl", alu_ctrl, 3'b000);

        // Hold: ADD x9 = x0 + x7 held with out_ready=0
        step();
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 32'h0, 5'd0, 5'd7, 5'd9, 32'h0, 32'h22, 32'h0);
        step();
        in_valid = 1'b0;
        check("hold_valid", out_valid, 1);
        check("hold_b_initial", alu_b, 32'h22);
        check("hold_in_ready", in_ready, 0);
        fwd_wb_valid  = 1'b1; fwd_wb_rd  = 5'd7; fwd_wb_data  = 32'h55;
        fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h99;
        step();
        check("hold_refresh_wb_b", alu_b, FWD ? 32'h55 : 32'h22);
        check("hold_x0_a", alu_a, 32'h0);
        fwd_mem_rd = 5'd7; fwd_mem_data = 32'h66;
        fwd_wb_data = 32'h77;
        step();
        clear_fwd();
        check("hold_refresh_mem_b", alu_b, FWD ? 32'h66 : 32'h22);
        check("hold_still_valid", out_valid, 1);
        check("hold_rd", out_rd, 9);

        // Flush concurrent with in_valid while holding
        drive(7'b0110111, 3'b000, 1'b0, 32'h0, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'hABC000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_hold_valid", out_valid, 0);
        step();
        check("flush_hold_dropped", out_valid, 0);

        // Flush beats capture when the stage is empty
        drive(7'b0110111, 3'b000, 1'b0, 32'h0, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'hABC000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_empty_valid", out_valid, 0);

        // Back-to-back: ADDI, ANDI, OR with out_ready=1 every cycle
        drive(7'b0010011, 3'b000, 1'b0, 32'h0, 5'd1, 5'd0, 5'd11, 32'd100, 32'h0, 32'd1);
        step();
        check("b2b0_valid", out_valid, 1);
        check("b2b0_a", alu_a, 100);
        drive(7'b0010011, 3'b111, 1'b0, 32'h0, 5'd2, 5'd0, 5'd12, 32'd200, 32'h0, 32'hF);
        step();
        check("b2b1_valid", out_valid, 1);
        check("b2b1_a", alu_a, 200);
        check("b2b1_ctrl", alu_ctrl, 3'b010);
        drive(7'b0110011, 3'b110, 1'b0, 32'h0, 5'd3, 5'd4, 5'd13, 32'd300, 32'd5, 32'h0);
        step();
        in_valid = 1'b0;
        check("b2b2_valid", out_valid, 1);
        check("b2b2_a", alu_a, 300);
        check("b2b2_b", alu_b, 5);
        check("b2b2_ctrl", alu_ctrl, 3'b011);
        step();
        check("b2b_end_valid", out_valid, 0);

        // Illegal opcode
        drive(7'b1110011, 3'b000, 1'b0, 32'h0, 5'd1, 5'd2, 5'd5, 32'h1234, 32'h5678, 32'h9);
        step();
        in_valid = 1'b0;
        check("ill_flag", out_illegal, 1);
        check("ill_wen", out_wen, 0);
        check("ill_ctrl", alu_ctrl, 3'b000);
        check("ill_a", alu_a, 0);
        check("ill_b", alu_b, 0);

        // LUI
        drive(7'b0110111, 3'b000, 1'b0, 32'h4000, 5'd7, 5'd0, 5'd8, 32'hDEAD, 32'h0, 32'h12345000);
        step();
        in_valid = 1'b0;
        check("lui_a", alu_a, 0);
        check("lui_b", alu_b, 32'h12345000);
        check("lui_wen", out_wen, 1);
        check("lui_illegal", out_illegal, 0);

        // AUIPC
        drive(7'b0010111, 3'b000, 1'b0, 32'h1000, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h20);
        step();
        in_valid = 1'b0;
        check("auipc_a", alu_a, 32'h1000);
        check("auipc_b", alu_b, 32'h20);

        // Store: address add, no writeback
        drive(7'b0100011, 3'b010, 1'b0, 32'h0, 5'd2, 5'd3, 5'd4, 32'h80, 32'h5, 32'h4);
        step();
        in_valid = 1'b0;
        check("store_a", alu_a, 32'h80);
        check("store_b", alu_b, 32'h4);
        check("store_wen", out_wen, 0);

        // Branch: SUB of rs1, rs2, no writeback
        drive(7'b1100011, 3'b000, 1'b0, 32'h0, 5'd2, 5'd3, 5'd4, 32'h9, 32'h6, 32'h40);
        step();
        in_valid = 1'b0;
        check("branch_ctrl", alu_ctrl, 3'b001);
        check("branch_b", alu_b, 32'h6);
        check("branch_wen", out_wen, 0);

        // R-type with rd=x0: no writeback
        drive(7'b0110011, 3'b000, 1'b0, 32'h0, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 32'h0);
        step();
        in_valid = 1'b0;
        check("rd0_wen", out_wen, 0);

        // Reset mid-operation discards held instruction
        out_ready = 1'b0;
        drive(7'b0010011, 3'b000, 1'b0, 32'h0, 5'd1, 5'd0, 5'd3, 32'h42, 32'h0, 32'h1);
        step();
        in_valid = 1'b0;
        check("midrst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_a", alu_a, 0);
        check("midrst_rd", out_rd, 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("midrst_after_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue pipeline stage directly upstream of the 32-bit ALU. It accepts decoded instructions from the decode stage over a valid/ready handshake and translates opcode/funct fields into the ALU's 3-bit control code. It selects and forwards operands and registers A, B and Control, so the ALU sees stable, registered inputs. It also tracks destination-register metadata for writeback.

## Interface
Parameters:
- XLEN, 32, datapath width
- REGW, 5, register index width

Ports (clock and reset first):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept
- in_opcode  in  7  instr[6:0]
- in_funct3  in  3  instr[14:12]
- in_funct7b5  in  1  instr[30]
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2, in_rd  in  REGW  register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- flush  in  1  kill held and incoming instruction
- fwd_mem_valid, fwd_wb_valid  in  1  forward sources valid
- fwd_mem_rd, fwd_wb_rd  in  REGW  forward destination
- fwd_mem_data, fwd_wb_data  in  XLEN  forward values
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  ALU/downstream consumes
- alu_a, alu_b  out  XLEN  registered operands
- alu_ctrl  out  3  ALU control code
- out_rd  out  REGW  destination
- out_wen  out  1  writes rd (0 for store/branch/illegal, or rd==0)
- out_illegal  out  1  unsupported encoding

## Operation
- ALU codes: 000 ADD, 001 SUB, 010 AND, 011 OR. Bit 2 is always driven 0.
- Decode:
  - R-type 0110011: f3 000 gives ADD (f7b5=0) or SUB (f7b5=1); f3 111 gives AND; f3 110 gives OR. A=rs1, B=rs2.
  - I-type 0010011: f3 000 ADD, 111 AND, 110 OR. A=rs1, B=imm.
  - Load 0000011 / store 0100011: ADD, A=rs1, B=imm.
  - Branch 1100011: SUB, A=rs1, B=rs2.
  - LUI 0110111: ADD, A=0, B=imm.
  - AUIPC 0010111: ADD, A=pc, B=imm.
  - Anything else: out_illegal=1, ctrl=ADD, A=B=0, out_wen=0.
- Forwarding (per source operand, only where the operand is a register):
  - MEM match beats WB match, which beats register-file data.
  - A match requires valid, rd equal to rs, and rs != 0.
- Pipeline register, one entry: in_ready = !out_valid | out_ready. Capture when in_valid & in_ready.
- Refresh while holding (out_valid & !out_ready): each cycle, a forward hit on held rs1/rs2 (same priority) overwrites the held operand register. Immediate, PC and zero operands never refresh.
- Flush: next edge clears out_valid and ignores in_valid that cycle. Flush beats capture.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- Reset (async assert, sync-safe release): out_valid=0, alu_a=0, alu_b=0, alu_ctrl=000, out_rd=0, out_wen=0, out_illegal=0, held rs indices=0.
- Outputs are stable while out_valid & !out_ready, except for operand refresh.
- Simultaneous accept and consume: new entry replaces old at the same edge; no bubble.
- Reset mid-operation: held instruction discarded.

## Configuration
- ALU_ISSUE_FWD_EN defined: forwarding and hold-refresh as above.
- ALU_ISSUE_FWD_EN undefined: fwd_* inputs ignored; operands come only from register-file/imm/pc/zero; no refresh. The hazard unit must stall instead.

## Structure
- Shared package alu_pkg holds:
  - ALU_ADD/SUB/AND/OR codes
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC)
  - operand-select enum (REG, IMM, PC, ZERO)
- Sub-module alu_ctrl_dec: combinational decode of opcode/funct3/funct7b5 to ctrl, A-select, B-select, wen, illegal.

## Test plan
- Reset, then R-type SUB: rs1_data=10, rs2_data=3, f7b5=1, out_ready=1 -> next cycle out_valid=1, alu_a=10, alu_b=3, alu_ctrl=001, out_wen=1.
- ORI, rs1=x5, imm=0x0F0, fwd_mem_valid=1, fwd_mem_rd=5, fwd_mem_data=0x100, fwd_wb same rd data 0x200 -> alu_a=0x100, alu_b=0x0F0, ctrl=011.
- Hold: out_ready=0 with ADD held for rs2=x7; fwd_wb hits x7 with 0x55 -> alu_b becomes 0x55 next cycle; in_ready=0; rs1 with rs1=x0 never forwarded.
- Back-to-back: three instructions with out_ready=1 every cycle -> three consecutive out_valid cycles, in order.
- Flush concurrent with in_valid while holding -> out_valid=0 next cycle, input dropped.
- Opcode 1110011 -> out_illegal=1, out_wen=0, ctrl=000. LUI imm=0x12345000 -> alu_a=0, alu_b=0x12345000.
